// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel output framer:
//   PIX_W           - RGB pixel width (24 bits)
//   ENTRY_W         - buffered entry width {sof, eol, eof, pixel} (27 bits)
//   pix_entry_t     - packed layout of one buffered entry
//   framer_state_e  - framer FSM encoding (IDLE=0, STREAM=1, FLUSH=2)
//   make_entry()    - packs a pixel together with its frame markers
// ---------------------------------------------------------------------------
package pixel_pkg;

  localparam int PIX_W   = 24;
  localparam int ENTRY_W = PIX_W + 3;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic             eof;
    logic [PIX_W-1:0] pixel;
  } pix_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } framer_state_e;

  function automatic pix_entry_t make_entry(
    input logic             sof,
    input logic             eol,
    input logic             eof,
    input logic [PIX_W-1:0] pixel
  );
    pix_entry_t e;
    e.sof   = sof;
    e.eol   = eol;
    e.eof   = eof;
    e.pixel = pixel;
    return e;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
// First-word-fall-through buffer: the oldest entry is always presented on
// rdata_o while empty_o is low, so a word pushed into an empty buffer is
// visible right after the pushing edge.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   push_i, wdata_i   - write request and data (ignored while full)
//   pop_i             - read request (ignored while empty)
//   rdata_o           - head entry
//   full_o, empty_o   - occupancy flags
//   count_o           - number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pixel_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next pointer and occupancy; simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/pixel_out_framer.sv
// ---------------------------------------------------------------------------
// pixel_out_framer
// Takes pixels from the transform stage, tags each accepted pixel with its
// frame position markers (sof/eol/eof), buffers them in a FWFT FIFO and
// presents them to a valid/ready sink. Once the last pixel of a frame is
// accepted, input is blocked until that pixel has left the buffer, so two
// frames never share the buffer.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   in_valid/in_data/in_ready - pixel input handshake
//   out_valid/out_ready       - beat output handshake
//   out_data, out_sof/eol/eof - head pixel and its markers (0 when empty)
//   frame_done                - one-cycle pulse after the eof beat pops
//   overflow                  - sticky: a pixel arrived while the FIFO was full
//   busy                      - a frame is in progress (STREAM or FLUSH)
//   frame_sum                 - only with FRAMER_CHECKSUM_EN: mod-2^24 sum of
//                               the popped pixels of the current frame
// Optional feature macro: FRAMER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module pixel_out_framer
  import pixel_pkg::*;
#(
  parameter int IMG_W      = 1024,
  parameter int IMG_H      = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy
`ifdef FRAMER_CHECKSUM_EN
  ,
  output logic [PIX_W-1:0] frame_sum
`endif
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  framer_state_e      state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CW-1:0]      fifo_count_unused_s;
  logic [ENTRY_W-1:0] head_raw_s;
  pix_entry_t         head_s;
  pix_entry_t         in_entry_s;
  logic               accept_s;
  logic               pop_s;
  logic               sof_s;
  logic               eol_s;
  logic               eof_s;

  // Markers describe the position of the pixel being accepted this cycle.
  assign sof_s      = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
  assign eol_s      = (x_q == X_LAST);
  assign eof_s      = eol_s && (y_q == Y_LAST);
  assign in_entry_s = make_entry(sof_s, eol_s, eof_s, in_data);

  // Reset is folded in so the source sees not-ready for the whole reset.
  assign in_ready  = rst & ~fifo_full_s & (state_q != FLUSH);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = ~fifo_empty_s;
  assign pop_s     = out_valid & out_ready;
  assign head_s    = pix_entry_t'(head_raw_s);

  // Head fields are masked while empty so stale storage never leaks out.
  assign out_data   = out_valid ? head_s.pixel : {PIX_W{1'b0}};
  assign out_sof    = out_valid & head_s.sof;
  assign out_eol    = out_valid & head_s.eol;
  assign out_eof    = out_valid & head_s.eof;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (accept_s),
    .wdata_i (in_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_unused_s)
  );

  // Column/row position; only accepted pixels advance it, drops do not.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept_s) begin
      if (eol_s) begin
        x_d = {XW{1'b0}};
        if (y_q == Y_LAST) begin
          y_d = {YW{1'b0}};
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Frame FSM next state plus the sticky drop flag and done pulse.
  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q | (in_valid & fifo_full_s);
    frame_done_d = pop_s & head_s.eof;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          // A one-pixel frame goes straight to FLUSH.
          state_d = eof_s ? FLUSH : STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (accept_s && eof_s) begin
          state_d = FLUSH;
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        // The eof beat is the last entry of the frame in the buffer.
        if (pop_s && head_s.eof) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= {XW{1'b0}};
      y_q          <= {YW{1'b0}};
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  logic [PIX_W-1:0] sum_q, sum_d;

  // Running sum of popped pixels; a popped sof beat restarts the sum.
  always_comb begin
    sum_d = sum_q;
    if (pop_s) begin
      if (head_s.sof) begin
        sum_d = head_s.pixel;
      end else begin
        sum_d = sum_q + head_s.pixel;
      end
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= {PIX_W{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_pixel_out_framer.sv
module tb_pixel_out_framer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DEPTH = 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic [23:0] in_data   = 24'h0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic        frame_done;
  logic        overflow;
  logic        busy;
`ifdef FRAMER_CHECKSUM_EN
  logic [23:0] frame_sum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_out_framer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
`ifdef FRAMER_CHECKSUM_EN
    ,
    .frame_sum  (frame_sum)
`endif
  );

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_sof, out_eol, out_eof, frame_done, overflow, busy} !== 8'h00
        || out_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b data=%h, expected ctl=00000000 data=000000",
               {in_ready, out_valid, out_sof, out_eol, out_eof, frame_done, overflow, busy}, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got in_ready=%b, expected 1", in_ready);
    end
  endtask

  // One full 4x2 frame, pixels base..base+7, sink always ready.
  task automatic test_stream(input logic [23:0] base);
    logic [27:0] got;
    logic [27:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 8) begin
        exp = {1'b1, (k == 1), (k == 4 || k == 8), (k == 8), base + 24'(k - 1)};
        got = {out_valid, out_sof, out_eol, out_eof, out_data};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL stream_beat%0d: got v/sof/eol/eof/data=%h, expected %h", k, got, exp);
        end
      end
      if (k == 8) begin
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
          errors++;
          $display("FAIL stream_flush: got in_ready/busy=%b, expected 01", {in_ready, busy});
        end
      end
      if (k == 9) begin
        checks++;
        if ({frame_done, busy, out_valid, in_ready} !== 4'b1001) begin
          errors++;
          $display("FAIL stream_done: got done/busy/valid/ready=%b, expected 1001",
                   {frame_done, busy, out_valid, in_ready});
        end
      end
      if (k == 10) begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++;
          $display("FAIL stream_done_pulse: got frame_done=%b, expected 0", frame_done);
        end
      end
      in_valid = (k < 8);
      in_data  = base + 24'(k);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_overflow: got %b, expected 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] got;
    out_ready = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        got = {out_valid, out_sof, out_data};
        checks++;
        if (got !== {1'b1, 1'b1, 24'h000001}) begin
          errors++;
          $display("FAIL bp_hold%0d: got v/sof/data=%h, expected 3000001", k, got);
        end
      end
      checks++;
      if (in_ready !== (k < 4)) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b, expected %b", k, in_ready, (k < 4));
      end
      if (k == 5) begin
        checks++;
        if (overflow !== 1'b1) begin
          errors++;
          $display("FAIL bp_overflow: got %b, expected 1", overflow);
        end
      end
      in_valid = (k <= 4);
      in_data  = 24'(k + 1);
    end
    out_ready = 1'b1;
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      if (j <= 2) begin
        got = {out_valid, out_eol, 24'(j + 2)};
        checks++;
        if ({out_valid, out_eol, out_data} !== {1'b1, (j == 2), 24'(j + 2)}) begin
          errors++;
          $display("FAIL bp_drain%0d: got v/eol/data=%h, expected %h", j,
                   {out_valid, out_eol, out_data}, {1'b1, (j == 2), 24'(j + 2)});
        end
      end else begin
        checks++;
        if ({out_valid, overflow, busy} !== 3'b011) begin
          errors++;
          $display("FAIL bp_sticky: got valid/overflow/busy=%b, expected 011",
                   {out_valid, overflow, busy});
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [27:0] got;
    out_ready = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      in_valid = (k < 3);
      in_data  = 24'hB00001 + 24'(k);
    end
    // Row 1 resumes at column 0 because the dropped pixel did not count.
    got = {out_valid, out_sof, out_eol, out_eof, out_data};
    checks++;
    if (got !== {4'b1000, 24'hB00001}) begin
      errors++;
      $display("FAIL mid_head1: got %h, expected 8b00001", got);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    got = {out_valid, out_sof, out_eol, out_eof, out_data};
    checks++;
    if (got !== {4'b1000, 24'hB00003}) begin
      errors++;
      $display("FAIL mid_head3: got %h, expected 8b00003", got);
    end
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sof, out_eol, out_eof, frame_done, overflow, busy} !== 8'h00
        || out_data !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got ctl=%b data=%h, expected ctl=00000000 data=000000",
               {in_ready, out_valid, out_sof, out_eol, out_eof, frame_done, overflow, busy}, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_stream(24'hA00000);
  endtask

  task automatic test_back_to_back();
    int sent;
    int beats;
    int p;
    logic [27:0] exp;
    sent = 0;
    beats = 0;
    out_ready = 1'b1;
    for (int n = 0; n <= 21; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        p = beats % 8;
        exp = {1'b1, (p == 0), (p == 3 || p == 7), (p == 7), 24'(beats + 1)};
        checks++;
        if ({out_valid, out_sof, out_eol, out_eof, out_data} !== exp) begin
          errors++;
          $display("FAIL b2b_beat%0d: got %h, expected %h", beats,
                   {out_valid, out_sof, out_eol, out_eof, out_data}, exp);
        end
        beats++;
      end
      checks++;
      if (frame_done !== (n == 9 || n == 18)) begin
        errors++;
        $display("FAIL b2b_done_n%0d: got %b, expected %b", n, frame_done, (n == 9 || n == 18));
      end
      if (n == 8 || n == 17 || n == 9) begin
        checks++;
        if (in_ready !== (n == 9)) begin
          errors++;
          $display("FAIL b2b_ready_n%0d: got %b, expected %b", n, in_ready, (n == 9));
        end
      end
      if (sent < 16) begin
        in_valid = 1'b1;
        in_data  = 24'(sent + 1);
        if (in_ready === 1'b1) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (beats != 16) begin
      errors++;
      $display("FAIL b2b_beats: got %0d, expected 16", beats);
    end
  endtask

`ifdef FRAMER_CHECKSUM_EN
  task automatic test_checksum();
    logic [23:0] vals [8];
    vals = '{24'hFFFFFF, 24'h000002, 24'h000001, 24'h000001,
             24'h000001, 24'h000001, 24'h000001, 24'h000001};
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++;
        if ({frame_done, frame_sum} !== {1'b1, 24'h000007}) begin
          errors++;
          $display("FAIL checksum: got done=%b sum=%h, expected done=1 sum=000007",
                   frame_done, frame_sum);
        end
      end
      in_valid = (k < 8);
      in_data  = (k < 8) ? vals[k] : 24'h0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream(24'h000001);
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
`ifdef FRAMER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
